// File: rtl/axi4_lite_mem_slave.sv
// AXI4-Lite slave over a 64-bit byte-writable memory with independent read/write FSMs.
// Optional: define AXI4_LITE_MEM_SLAVE_DECERR_EN to answer out-of-range addresses with DECERR.
module axi4_lite_mem_slave #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [27:0] awaddr_i,
  input  logic [2:0]  awprot_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  wstrb_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  input  logic [27:0] araddr_i,
  input  logic [2:0]  arprot_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [63:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [31:0] wr_count_o,
  output logic [31:0] rd_count_o
);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} r_state_t;

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  logic [63:0] mem [DEPTH_WORDS];

  logic [27:0] awaddr_reg;
  logic [27:0] araddr_reg;
  logic [63:0] wdata_reg;
  logic [7:0]  wstrb_reg;
  logic [63:0] ram_rdata_reg;
  logic [31:0] wr_count_reg;
  logic [31:0] rd_count_reg;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic w_oob, r_oob, mem_we;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic unused_ok;

  assign aw_hs = awvalid_i & awready_o;
  assign w_hs  = wvalid_i & wready_o;
  assign b_hs  = bvalid_o & bready_i;
  assign ar_hs = arvalid_i & arready_o;
  assign r_hs  = rvalid_o & rready_i;

  assign w_idx = awaddr_reg[3+IDX_W-1:3];
  assign r_idx = araddr_reg[3+IDX_W-1:3];

`ifdef AXI4_LITE_MEM_SLAVE_DECERR_EN
  assign w_oob = |awaddr_reg[27:3+IDX_W];
  assign r_oob = |araddr_reg[27:3+IDX_W];
`else
  assign w_oob = 1'b0;
  assign r_oob = 1'b0;
`endif

  assign unused_ok = ^{awprot_i, arprot_i, awaddr_reg, araddr_reg};

  // ---------------- write FSM ----------------
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      w_state_reg <= W_IDLE;
    end else begin
      w_state_reg <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_next = W_COMMIT;
        else if (aw_hs)    w_state_next = W_ADDR;
        else if (w_hs)     w_state_next = W_DATA;
      end
      W_ADDR:   if (w_hs)     w_state_next = W_COMMIT;
      W_DATA:   if (aw_hs)    w_state_next = W_COMMIT;
      W_COMMIT:               w_state_next = W_RESP;
      W_RESP:   if (bready_i) w_state_next = W_IDLE;
      default:                w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready_o = (w_state_reg == W_IDLE) || (w_state_reg == W_DATA);
    wready_o  = (w_state_reg == W_IDLE) || (w_state_reg == W_ADDR);
    bvalid_o  = (w_state_reg == W_RESP);
    bresp_o   = (w_state_reg == W_RESP && w_oob) ? 2'b11 : 2'b00;
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state_reg <= R_IDLE;
    end else begin
      r_state_reg <= r_state_next;
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (ar_hs)    r_state_next = R_READ;
      R_READ:                r_state_next = R_RESP;
      R_RESP:  if (rready_i) r_state_next = R_IDLE;
      default:               r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready_o = (r_state_reg == R_IDLE);
    rvalid_o  = (r_state_reg == R_RESP);
    rresp_o   = (r_state_reg == R_RESP && r_oob) ? 2'b11 : 2'b00;
    rdata_o   = (r_state_reg == R_RESP && !r_oob) ? ram_rdata_reg : 64'd0;
  end

  // ---------------- capture registers and counters ----------------
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      awaddr_reg   <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      araddr_reg   <= '0;
      wr_count_reg <= '0;
      rd_count_reg <= '0;
    end else begin
      if (aw_hs) awaddr_reg <= awaddr_i;
      if (w_hs) begin
        wdata_reg <= wdata_i;
        wstrb_reg <= wstrb_i;
      end
      if (ar_hs) araddr_reg <= araddr_i;
      if (b_hs)  wr_count_reg <= wr_count_reg + 32'd1;
      if (r_hs)  rd_count_reg <= rd_count_reg + 32'd1;
    end
  end

  assign wr_count_o = wr_count_reg;
  assign rd_count_o = rd_count_reg;

  // ---------------- memory ----------------
  // Reset gates the commit so a write pending at the reset edge is dropped.
  assign mem_we = reset_n_i && (w_state_reg == W_COMMIT) && !w_oob;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb_reg[i]) mem[w_idx][8*i +: 8] <= wdata_reg[8*i +: 8];
      end
    end
  end

  // Read-before-write: a same-edge commit is not visible to this read.
  always_ff @(posedge clk_i) begin
    if (r_state_reg == R_READ) ram_rdata_reg <= mem[r_idx];
  end

endmodule
